// File: rtl/mem_pkg.sv
// Shared encodings for the MEM pipeline stage: result-select codes,
// RV32I load/store funct3 values and the bus FSM state type.
package mem_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for stores, load extraction/extension
// and alignment checking. Unknown funct3 codes behave as word accesses.
module load_store_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misalign
);

  function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]      bs;
    logic signed [XLEN-1:0] r;
    bs = b;
    r  = bs;
    if (sgn) return r;
    return {{(XLEN-8){1'b0}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0]     hs;
    logic signed [XLEN-1:0] r;
    hs = h;
    r  = hs;
    if (sgn) return r;
    return {{(XLEN-16){1'b0}}, h};
  endfunction

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    load_data = ext_byte(shifted[7:0], 1'b1);
      F3_BU:   load_data = ext_byte(shifted[7:0], 1'b0);
      F3_H:    load_data = ext_half(shifted[15:0], 1'b1);
      F3_HU:   load_data = ext_half(shifted[15:0], 1'b0);
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    wstrb = 4'b1111;
    wdata = store_data;
    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {(XLEN/8){store_data[7:0]}};
      end
      F3_H: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {(XLEN/16){store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Store funct3 codes outside SB/SH are word stores, so BU/HU only apply to loads.
  always_comb begin
    misalign = 1'b0;
    case (funct3)
      F3_B:    misalign = 1'b0;
      F3_H:    misalign = addr_lo[0];
      F3_BU:   misalign = is_store ? (addr_lo != 2'b00) : 1'b0;
      F3_HU:   misalign = is_store ? (addr_lo != 2'b00) : addr_lo[0];
      default: misalign = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: ready-handshaked data-memory bus FSM plus MEM/WB register.
// Optional macro MEM_TIMEOUT_EN aborts accesses after TIMEOUT_CYCLES busy cycles.
module memory_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] PCPlus4M,
  output logic            StallM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic            MisalignW,
  output logic            BusErrW
);

  mem_state_t      state, state_nx;
  logic            acc, misalign, timeout;
  logic            start, done, capture, mis_ret;
  logic [3:0]      lane_strb;
  logic [XLEN-1:0] lane_wdata, load_data;

  assign acc = MemWriteM | (ResultSrcM == RES_MEM);

  load_store_align #(.XLEN(XLEN)) u_align (
    .funct3    (Funct3M),
    .is_store  (MemWriteM),
    .addr_lo   (ALUResultM[1:0]),
    .store_data(WriteDataM),
    .rdata     (mem_rdata),
    .wstrb     (lane_strb),
    .wdata     (lane_wdata),
    .load_data (load_data),
    .misalign  (misalign)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt;

  // Holding the counter at zero while idle gives a clean start on BUSY entry.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) tmo_cnt <= '0;
    else if (!mem_ready)      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (state == BUSY) && !mem_ready &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    StallM   = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (acc && !misalign) begin
          start    = 1'b1;
          state_nx = BUSY;
          StallM   = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (timeout) begin
          state_nx = IDLE;
        end else begin
          StallM = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (rst) StallM = 1'b0;
  end

  assign capture = ((state == IDLE) && !start) || done || timeout;
  assign mis_ret = (state == IDLE) && acc && misalign;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Bus stage: control bits reset, address/data only load on a new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= 4'b0000;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= MemWriteM;
      mem_wstrb <= MemWriteM ? lane_strb : 4'b0000;
    end else if (done || timeout) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mem_addr  <= {ALUResultM[XLEN-1:2], 2'b00};
      mem_wdata <= lane_wdata;
    end
  end

  // MEM/WB stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= RES_ALU;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else if (start) begin
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
      BusErrW   <= 1'b0;
    end else if (capture) begin
      RegWriteW  <= RegWriteM && !mis_ret && !timeout;
      ResultSrcW <= ResultSrcM;
      ReadDataW  <= done ? load_data : '0;
      ALUResultW <= ALUResultM;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      MisalignW  <= mis_ret;
      BusErrW    <= timeout;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed, table-driven bench for memory_stage: lane steering, load extension,
// stall timing, misalignment, reset mid-access and (with MEM_TIMEOUT_EN) bus timeout.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallM, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        RegWriteW, MisalignW, BusErrW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RdW;

  int total = 0;
  int bad   = 0;

  memory_stage #(.TIMEOUT_CYCLES(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
    .ALUResultW(ALUResultW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          wait_n;
    logic        mis;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rd_exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    RegWriteM  = rw;
    ResultSrcM = rs;
    MemWriteM  = mw;
    Funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    RdM        = rd;
    PCPlus4M   = a + 32'h4;
  endtask

  task automatic nop();
    drive(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0);
  endtask

  // Called 1 time unit after a rising edge with the access already driven.
  // Returns 1 time unit after the edge that retires the access.
  task automatic run_access(input int wait_n, input logic [31:0] rdata, output int stalls,
                            output int busy, output logic [31:0] a_s, output logic [3:0] s_s,
                            output logic [31:0] d_s, output logic we_s);
    bit fin = 0;
    stalls = 0; busy = 0; a_s = 'x; s_s = 'x; d_s = 'x; we_s = 1'bx;
    for (int c = 0; c < 64 && !fin; c++) begin
      mem_ready = mem_req && (busy == wait_n);
      mem_rdata = rdata;
      #1;
      if (StallM) stalls++;
      if (mem_req) begin
        busy++;
        a_s = mem_addr; s_s = mem_wstrb; d_s = mem_wdata; we_s = mem_we;
      end
      fin = !StallM;
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL access_bound: got stall still high expected release within 64 cycles");
    end
  endtask

  int          stalls, busy;
  logic [31:0] a_s, d_s;
  logic [3:0]  s_s;
  logic        we_s;
  vec_t        v;

  initial begin
    //            st    f3      addr          wd            rdata         wait mis strb     wdata         rd_exp
    vt[0]  = '{1'b1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 32'h0,        0, 1'b0, 4'b1000, 32'hDDDD_DDDD, 32'h0};
    vt[1]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h1122_BEEF, 32'h0,        1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vt[2]  = '{1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vt[3]  = '{1'b1, 3'b000, 32'h0000_0100, 32'h0000_0055, 32'h0,        2, 1'b0, 4'b0001, 32'h5555_5555, 32'h0};
    vt[4]  = '{1'b0, 3'b000, 32'h0000_0202, 32'h0,        32'h0080_0000, 3, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80};
    vt[5]  = '{1'b0, 3'b100, 32'h0000_0202, 32'h0,        32'h0080_0000, 3, 1'b0, 4'b0000, 32'h0, 32'h0000_0080};
    vt[6]  = '{1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'h8001_0000, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001};
    vt[7]  = '{1'b0, 3'b101, 32'h0000_0202, 32'h0,        32'h8001_0000, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_8001};
    vt[8]  = '{1'b0, 3'b001, 32'h0000_0200, 32'h0,        32'h0000_7FFF, 0, 1'b0, 4'b0000, 32'h0, 32'h0000_7FFF};
    vt[9]  = '{1'b0, 3'b010, 32'h0000_0204, 32'h0,        32'hDEAD_BEEF, 2, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
    vt[10] = '{1'b0, 3'b000, 32'h0000_0201, 32'h0,        32'h0000_7F00, 0, 1'b0, 4'b0000, 32'h0, 32'h0000_007F};
    vt[11] = '{1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'hFF00_0000, 0, 1'b0, 4'b0000, 32'h0, 32'h0000_00FF};
    vt[12] = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vt[13] = '{1'b0, 3'b001, 32'h0000_0201, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vt[14] = '{1'b1, 3'b010, 32'h0000_0102, 32'h1234_5678, 32'h0,        0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vt[15] = '{1'b1, 3'b001, 32'h0000_0203, 32'h1234_5678, 32'h0,        0, 1'b1, 4'b0000, 32'h0, 32'h0};

    // Reset with a load presented: no stall and no request while rst is high.
    rst = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0;
    drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h10, 32'h0, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_regwrite", 32'(RegWriteW), 32'd0);
    chk("rst_aluresult", ALUResultW, 32'd0);
    nop();
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain ALU instruction.
    drive(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5);
    #1;
    chk("alu_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    chk("alu_regwrite", 32'(RegWriteW), 32'd1);
    chk("alu_rd", 32'(RdW), 32'd5);
    chk("alu_result", ALUResultW, 32'h1234);
    chk("alu_readdata", ReadDataW, 32'd0);
    chk("alu_req", 32'(mem_req), 32'd0);
    chk("alu_stall2", 32'(StallM), 32'd0);

    // mem_ready while idle must not start or retire anything.
    nop();
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_ready_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("idle_ready_req", 32'(mem_req), 32'd0);
    chk("idle_ready_readdata", ReadDataW, 32'd0);

    // Table: accesses issued back to back.
    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      drive(!v.st, v.st ? 2'b00 : 2'b01, v.st, v.f3, v.addr, v.wd, 5'(i + 1));
      if (v.mis) begin
        #1;
        chk($sformatf("v%0d_mis_stall", i), 32'(StallM), 32'd0);
        chk($sformatf("v%0d_mis_req", i), 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_misalignw", i), 32'(MisalignW), 32'd1);
        chk($sformatf("v%0d_mis_regwrite", i), 32'(RegWriteW), 32'd0);
        chk($sformatf("v%0d_mis_req2", i), 32'(mem_req), 32'd0);
      end else begin
        run_access(v.wait_n, v.rdata, stalls, busy, a_s, s_s, d_s, we_s);
        chk($sformatf("v%0d_stall_cycles", i), 32'(stalls), 32'(v.wait_n + 1));
        chk($sformatf("v%0d_busy_cycles", i), 32'(busy), 32'(v.wait_n + 1));
        chk($sformatf("v%0d_addr", i), a_s, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d_we", i), 32'(we_s), 32'(v.st));
        chk($sformatf("v%0d_wstrb", i), 32'(s_s), 32'(v.strb));
        chk($sformatf("v%0d_misalignw", i), 32'(MisalignW), 32'd0);
        if (v.st) begin
          chk($sformatf("v%0d_wdata", i), d_s, v.wdata);
          chk($sformatf("v%0d_st_regwrite", i), 32'(RegWriteW), 32'd0);
        end else begin
          chk($sformatf("v%0d_readdata", i), ReadDataW, v.rd_exp);
          chk($sformatf("v%0d_ld_regwrite", i), 32'(RegWriteW), 32'd1);
          chk($sformatf("v%0d_rd", i), 32'(RdW), 32'(i + 1));
          chk($sformatf("v%0d_resultsrc", i), 32'(ResultSrcW), 32'd1);
        end
      end
    end

    // Misalign flag lasts exactly one cycle.
    nop();
    @(posedge clk); #1;
    chk("mis_clear", 32'(MisalignW), 32'd0);
    chk("mis_clear_req", 32'(mem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // No ready at all: abort after four busy cycles.
    drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd9);
    run_access(1000, 32'h0, stalls, busy, a_s, s_s, d_s, we_s);
    chk("tmo_busy_cycles", 32'(busy), 32'd4);
    chk("tmo_stall_cycles", 32'(stalls), 32'd4);
    chk("tmo_req", 32'(mem_req), 32'd0);
    chk("tmo_buserr", 32'(BusErrW), 32'd1);
    chk("tmo_regwrite", 32'(RegWriteW), 32'd0);
    nop();
    #1;
    chk("tmo_idle_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    chk("tmo_buserr_clear", 32'(BusErrW), 32'd0);
`endif

    // Make the W register non-zero, then reset on the second busy cycle.
    drive(1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_5A5A, 32'h0, 5'd7);
    @(posedge clk); #1;
    drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    chk("rst_busy_req", 32'(mem_req), 32'd0);
    chk("rst_busy_we", 32'(mem_we), 32'd0);
    chk("rst_busy_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_busy_stall2", 32'(StallM), 32'd0);
    chk("rst_w_aluresult", ALUResultW, 32'd0);
    chk("rst_w_rd", 32'(RdW), 32'd0);
    chk("rst_w_pc4", PCPlus4W, 32'd0);
    chk("rst_w_regwrite", 32'(RegWriteW), 32'd0);
    rst = 1'b0;
    run_access(1, 32'h1234_5678, stalls, busy, a_s, s_s, d_s, we_s);
    chk("post_rst_stalls", 32'(stalls), 32'd2);
    chk("post_rst_addr", a_s, 32'h0000_0300);
    chk("post_rst_readdata", ReadDataW, 32'h1234_5678);
    chk("post_rst_regwrite", 32'(RegWriteW), 32'd1);
    chk("post_rst_rd", 32'(RdW), 32'd11);
    nop();
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage, directly downstream of the execute stage.
- Consumes the EX/MEM register outputs, performs loads and stores over a ready-handshaked data-memory bus, and owns the MEM/WB pipeline register.
- Steers byte lanes for stores and sign/zero-extends load data.
- Stalls the upstream pipeline while a bus access is outstanding, and flags misaligned accesses and bus timeouts to writeback.

Parameters:
- TIMEOUT_CYCLES, 16, number of BUSY cycles without mem_ready before the access is aborted (only with MEM_TIMEOUT_EN).
- XLEN, 32, data and address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- RegWriteM  in  1  register write enable from EX/MEM
- ResultSrcM  in  2  result select: 00 ALU, 01 memory, 10 PC+4
- MemWriteM  in  1  store enable
- Funct3M  in  3  access size/sign (RV32I load/store funct3)
- ALUResultM  in  32  effective address or ALU result
- WriteDataM  in  32  store data, unaligned (lane 0)
- RdM  in  5  destination register
- PCPlus4M  in  32  link value
- StallM  out  1  holds IF/ID/EX and EX/MEM registers
- mem_req  out  1  bus request, registered
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte strobes
- mem_ready  in  1  bus completes this cycle
- mem_rdata  in  32  read word, valid with mem_ready
- RegWriteW, ResultSrcW[2], ReadDataW[32], ALUResultW[32], RdW[5], PCPlus4W[32]  out  MEM/WB register
- MisalignW  out  1  misaligned access retired
- BusErrW  out  1  access aborted by timeout

Behaviour:
- Access condition: acc = MemWriteM | (ResultSrcM==01).
- Non-access instruction:
  - MEM/WB captures the M inputs on the next edge.
  - StallM=0.
  - ReadDataW=0.
- FSM has two states, IDLE and BUSY.
- IDLE, acc, aligned:
  - Go to BUSY.
  - Register mem_req=1, mem_we=MemWriteM, mem_addr, mem_wdata, mem_wstrb (strobe is 0 for loads).
  - StallM=1 (combinational).
  - MEM/WB loads a bubble: RegWriteW=0, MisalignW=0, BusErrW=0.
- BUSY, mem_ready=0:
  - Hold all bus outputs.
  - StallM=1.
  - MEM/WB holds the bubble.
- BUSY, mem_ready=1:
  - StallM=0.
  - MEM/WB captures the M inputs, with ReadDataW = extended mem_rdata.
  - mem_req=0 on the next edge; go to IDLE.
- Minimum access latency: 2 cycles in M (IDLE + BUSY with immediate ready). A back-to-back access re-enters BUSY from IDLE after one cycle.
- Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - No bus request; stays IDLE; StallM=0.
  - MEM/WB captures with RegWriteW=0, MisalignW=1 for one cycle.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{byte}}.
  - SH: wstrb = 0011<<addr[1:0], wdata = {2{half}}.
  - SW: wstrb = 1111.
- Load extension: byte/half selected by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Other funct3 values are treated as LW/SW.
- mem_ready seen in IDLE is ignored.
- Reset, including mid-BUSY:
  - State goes to IDLE; mem_req=0, mem_we=0, mem_wstrb=0.
  - All W outputs are 0.
  - StallM=0 during reset; the timeout counter is cleared.
  - An outstanding bus transaction is abandoned; the bus is responsible for dropping it.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When the counter reaches TIMEOUT_CYCLES-1 without ready: drop mem_req, go to IDLE, StallM=0 that cycle.
  - MEM/WB captures with RegWriteW=0 and BusErrW=1 for one cycle.
  - mem_ready has priority if it coincides with the timeout cycle.
- Undefined: no counter; BUSY waits indefinitely; BusErrW tied 0.

Decomposition:
- Package mem_pkg holds:
  - ResultSrc encodings: RES_ALU, RES_MEM, RES_PC4.
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum mem_state_t: IDLE, BUSY.
- Sub-module load_store_align (combinational) takes funct3, addr[1:0], store data and read word. It returns wstrb, shifted wdata, extended load data and the misalign flag.
- memory_stage holds the FSM, counter, bus registers and MEM/WB register.

Test Plan:
- ALU instruction, ResultSrcM=00, RdM=5, ALUResultM=0x1234 -> next edge RegWriteW=1, RdW=5, ALUResultW=0x1234; StallM=0 throughout; mem_req never high.
- SB at addr 0x103, data 0xAABBCCDD, ready on the first BUSY cycle:
  - mem_addr=0x100, wstrb=1000, wdata=0xDDDDDDDD.
  - StallM high exactly 1 cycle.
  - RegWriteW=0 after completion.
- LB at addr 0x202, ready after 3 BUSY cycles, rdata=0x00800000 -> StallM high 4 cycles; ReadDataW=0xFFFFFF80. The same access as LBU yields 0x00000080.
- LW at addr 0x006 -> no mem_req; StallM=0; next edge MisalignW=1, RegWriteW=0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req drops after 4 BUSY cycles; BusErrW=1 for one cycle; FSM returns to IDLE.
- rst asserted on the 2nd BUSY cycle -> next edge mem_req=0, StallM=0, all W outputs 0. A subsequent load completes normally.
